// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the fetch unit and the controller.
//   NPC_*            next-PC select encodings driven by CTRL on npcctrol
//   fetch_state_e    fetch FSM states
//   RESET_PC_DEFAULT default boot address
//   MAX_WAIT_DEFAULT default imem response timeout in cycles
package cpu_pkg;

    localparam logic [1:0] NPC_SEQ = 2'b00;
    localparam logic [1:0] NPC_JMP = 2'b01;
    localparam logic [1:0] NPC_BR  = 2'b10;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
    localparam int unsigned MAX_WAIT_DEFAULT = 16;

    typedef enum logic [2:0] {
        StBoot,
        StReq,
        StWait,
        StHold,
        StHalt
    } fetch_state_e;

endpackage

// File: rtl/npc_calc.sv
// Next-PC calculation for the fetch unit (purely combinational).
//   pc        in  32  address of the current instruction
//   instr     in  32  current instruction (target / imm16 fields used)
//   npcctrol  in   2  next-PC select (seq, jump, branch; 11 behaves as seq)
//   npc       out 32  selected next PC
//   pc_plus4  out 32  pc + 4, wraps modulo 2^32
module npc_calc
    import cpu_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [31:0] instr,
    input  logic [1:0]  npcctrol,
    output logic [31:0] npc,
    output logic [31:0] pc_plus4
);

    logic [31:0] br_offset;
    logic        unused_op;

    // Opcode bits are decoded by CTRL, not here.
    assign unused_op = ^instr[31:26];

    always_comb begin
        pc_plus4  = pc + 32'd4;
        br_offset = {{14{instr[15]}}, instr[15:0], 2'b00};
        case (npcctrol)
            NPC_JMP: npc = {pc_plus4[31:28], instr[25:0], 2'b00};
            NPC_BR:  npc = pc_plus4 + br_offset;
            default: npc = pc_plus4;
        endcase
    end

endmodule

// File: rtl/ifu_fetch.sv
// Instruction-fetch unit: PC register, fetch FSM, instruction latch and imem timeout.
//   clk, reset         clock; asynchronous active-high reset
//   advance, npcctrol  retire current instruction and choose next PC
//   imem_req/addr      fetch request, held until imem_gnt
//   imem_gnt/rvalid    grant and read-data-valid from instruction memory
//   imem_rdata         instruction word
//   instr, instr_valid current instruction, stable while valid
//   pc, pc_plus4       address of current instruction and its successor
//   fetch_err          sticky imem timeout flag, cleared only by reset
module ifu_fetch
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int unsigned MAX_WAIT = MAX_WAIT_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        advance,
    input  logic [1:0]  npcctrol,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        fetch_err
);

    localparam int unsigned CntW = $clog2(MAX_WAIT + 1);

    if (RESET_PC[1:0] != 2'b00) begin : g_reset_pc_check
        $error("ifu_fetch: RESET_PC must be word aligned");
    end
    if (MAX_WAIT < 1) begin : g_max_wait_check
        $error("ifu_fetch: MAX_WAIT must be at least 1");
    end

    fetch_state_e    state_q;
    logic [31:0]     pc_q;
    logic [31:0]     instr_q;
    logic            req_q;
    logic            valid_q;
    logic            err_q;
    logic [CntW-1:0] cnt_q;
    logic [31:0]     npc;
    logic [31:0]     pc_plus4_w;

    npc_calc u_npc_calc (
        .pc       (pc_q),
        .instr    (instr_q),
        .npcctrol (npcctrol),
        .npc      (npc),
        .pc_plus4 (pc_plus4_w)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StBoot;
            pc_q    <= RESET_PC;
            instr_q <= 32'h0;
            req_q   <= 1'b0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                StBoot: begin
                    state_q <= StReq;
                    req_q   <= 1'b1;
                end
                StReq: begin
                    if (imem_gnt) begin
                        req_q <= 1'b0;
                        cnt_q <= '0;
                        // Zero-wait memory: data returns in the grant cycle.
                        if (imem_rvalid) begin
                            instr_q <= imem_rdata;
                            valid_q <= 1'b1;
                            state_q <= StHold;
                        end else begin
                            state_q <= StWait;
                        end
                    end
                end
                StWait: begin
                    if (imem_rvalid) begin
                        instr_q <= imem_rdata;
                        valid_q <= 1'b1;
                        state_q <= StHold;
                    end else if (cnt_q == CntW'(MAX_WAIT - 1)) begin
                        // MAX_WAIT cycles elapsed with no data.
                        err_q   <= 1'b1;
                        state_q <= StHalt;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StHold: begin
                    if (advance) begin
                        pc_q    <= npc;
                        valid_q <= 1'b0;
                        req_q   <= 1'b1;
                        state_q <= StReq;
                    end
                end
                StHalt: begin
                    req_q   <= 1'b0;
                    valid_q <= 1'b0;
                end
                default: begin
                    req_q   <= 1'b0;
                    valid_q <= 1'b0;
                    state_q <= StHalt;
                end
            endcase
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = pc_q;
    assign instr       = instr_q;
    assign instr_valid = valid_q;
    assign pc          = pc_q;
    assign pc_plus4    = pc_plus4_w;
    assign fetch_err   = err_q;

    // Read data is only legal in the wait state or together with the grant.
    a_rvalid_legal : assert property (@(posedge clk) disable iff (reset)
        imem_rvalid |-> (state_q == StWait || (state_q == StReq && imem_gnt)));

endmodule

// File: tb/tb_ifu_fetch.sv
module tb_ifu_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic        advance;
    logic [1:0]  npcctrol;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        fetch_err;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    ifu_fetch dut (
        .clk         (clk),
        .reset       (reset),
        .advance     (advance),
        .npcctrol    (npcctrol),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .instr_valid (instr_valid),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .fetch_err   (fetch_err)
    );

    // Wait (bounded) for a request, answer it with gnt+rvalid in the same cycle.
    task automatic serve_fetch(input logic [31:0] word);
        int n = 0;
        while (imem_req !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        tests_run++;
        if (imem_req !== 1'b1) begin
            tests_failed++;
            $display("FAIL serve_fetch_req: imem_req=%b, required 1 within 20 cycles", imem_req);
        end
        imem_gnt    = 1'b1;
        imem_rvalid = 1'b1;
        imem_rdata  = word;
        @(negedge clk);
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'hDEAD_BEEF;
    endtask

    task automatic advance_once(input logic [1:0] ctrl);
        advance  = 1'b1;
        npcctrol = ctrl;
        @(negedge clk);
        advance  = 1'b0;
        npcctrol = 2'b00;
    endtask

    task automatic test_reset;
        reset       = 1'b1;
        advance     = 1'b0;
        npcctrol    = 2'b00;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        repeat (3) @(negedge clk);
        tests_run += 5;
        if (pc !== 32'h0000_3000) begin tests_failed++;
            $display("FAIL rst_pc: got %h, required 00003000", pc); end
        if (instr !== 32'h0) begin tests_failed++;
            $display("FAIL rst_instr: got %h, required 00000000", instr); end
        if (instr_valid !== 1'b0) begin tests_failed++;
            $display("FAIL rst_valid: got %b, required 0", instr_valid); end
        if (imem_req !== 1'b0) begin tests_failed++;
            $display("FAIL rst_req: got %b, required 0", imem_req); end
        if (fetch_err !== 1'b0) begin tests_failed++;
            $display("FAIL rst_err: got %b, required 0", fetch_err); end
        reset = 1'b0;
        tests_run++;
        if (imem_req !== 1'b0) begin tests_failed++;
            $display("FAIL boot_no_req: got %b, required 0", imem_req); end
        @(negedge clk);
        tests_run += 2;
        if (imem_req !== 1'b1) begin tests_failed++;
            $display("FAIL first_req: got %b, required 1", imem_req); end
        if (imem_addr !== 32'h0000_3000) begin tests_failed++;
            $display("FAIL first_addr: got %h, required 00003000", imem_addr); end
        imem_gnt    = 1'b1;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h2408_0001;
        @(negedge clk);
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        tests_run += 5;
        if (instr_valid !== 1'b1) begin tests_failed++;
            $display("FAIL first_valid: got %b, required 1", instr_valid); end
        if (instr !== 32'h2408_0001) begin tests_failed++;
            $display("FAIL first_instr: got %h, required 24080001", instr); end
        if (pc !== 32'h0000_3000) begin tests_failed++;
            $display("FAIL first_pc: got %h, required 00003000", pc); end
        if (pc_plus4 !== 32'h0000_3004) begin tests_failed++;
            $display("FAIL first_pc4: got %h, required 00003004", pc_plus4); end
        if (imem_req !== 1'b0) begin tests_failed++;
            $display("FAIL first_req_drop: got %b, required 0", imem_req); end
    endtask

    task automatic test_hold_stable;
        imem_gnt = 1'b1;
        for (int i = 0; i < 3; i++) begin
            imem_rdata = 32'hA5A5_0000 + i;
            @(negedge clk);
        end
        imem_gnt = 1'b0;
        tests_run += 3;
        if (instr !== 32'h2408_0001) begin tests_failed++;
            $display("FAIL hold_instr: got %h, required 24080001", instr); end
        if (instr_valid !== 1'b1) begin tests_failed++;
            $display("FAIL hold_valid: got %b, required 1", instr_valid); end
        if (pc !== 32'h0000_3000) begin tests_failed++;
            $display("FAIL hold_pc: got %h, required 00003000", pc); end
    endtask

    task automatic test_sequential;
        advance_once(2'b00);
        tests_run += 3;
        if (instr_valid !== 1'b0) begin tests_failed++;
            $display("FAIL seq_valid_drop: got %b, required 0", instr_valid); end
        if (imem_req !== 1'b1) begin tests_failed++;
            $display("FAIL seq_req: got %b, required 1", imem_req); end
        if (imem_addr !== 32'h0000_3004) begin tests_failed++;
            $display("FAIL seq_addr: got %h, required 00003004", imem_addr); end
        serve_fetch(32'h0000_0000);
        advance_once(2'b00);
        serve_fetch(32'h1000_FFFF);
        tests_run += 2;
        if (pc !== 32'h0000_3008) begin tests_failed++;
            $display("FAIL seq_pc2: got %h, required 00003008", pc); end
        if (instr !== 32'h1000_FFFF) begin tests_failed++;
            $display("FAIL seq_instr2: got %h, required 1000ffff", instr); end
    endtask

    task automatic test_branch;
        advance_once(2'b10);
        tests_run += 2;
        if (pc !== 32'h0000_3008) begin tests_failed++;
            $display("FAIL br_back_pc: got %h, required 00003008", pc); end
        if (imem_addr !== 32'h0000_3008) begin tests_failed++;
            $display("FAIL br_back_addr: got %h, required 00003008", imem_addr); end
        serve_fetch(32'h0000_0000);
        advance_once(2'b00);
        serve_fetch(32'h0000_0000);
        advance_once(2'b00);
        serve_fetch(32'h0800_0C10);
        tests_run++;
        if (pc !== 32'h0000_3010) begin tests_failed++;
            $display("FAIL br_walk_pc: got %h, required 00003010", pc); end
    endtask

    task automatic test_jump;
        advance_once(2'b01);
        tests_run++;
        if (pc !== 32'h0000_3040) begin tests_failed++;
            $display("FAIL jump_pc: got %h, required 00003040", pc); end
        // Far backward branch: 0x3044 - 0x20000 wraps below zero.
        serve_fetch(32'h1000_8000);
        advance_once(2'b10);
        tests_run++;
        if (pc !== 32'hFFFE_3044) begin tests_failed++;
            $display("FAIL br_neg_pc: got %h, required fffe3044", pc); end
        serve_fetch(32'h0BFF_FFFF);
        advance_once(2'b01);
        tests_run++;
        if (pc !== 32'hFFFF_FFFC) begin tests_failed++;
            $display("FAIL jump_top_pc: got %h, required fffffffc", pc); end
    endtask

    task automatic test_wrap;
        serve_fetch(32'h0000_0000);
        tests_run++;
        if (pc_plus4 !== 32'h0000_0000) begin tests_failed++;
            $display("FAIL wrap_pc4: got %h, required 00000000", pc_plus4); end
        advance_once(2'b00);
        tests_run += 2;
        if (pc !== 32'h0000_0000) begin tests_failed++;
            $display("FAIL wrap_pc: got %h, required 00000000", pc); end
        if (imem_addr !== 32'h0000_0000) begin tests_failed++;
            $display("FAIL wrap_addr: got %h, required 00000000", imem_addr); end
        // Advance while nothing is valid must be ignored.
        advance  = 1'b1;
        npcctrol = 2'b01;
        repeat (2) @(negedge clk);
        advance  = 1'b0;
        npcctrol = 2'b00;
        tests_run += 2;
        if (pc !== 32'h0000_0000) begin tests_failed++;
            $display("FAIL idle_adv_pc: got %h, required 00000000", pc); end
        if (imem_req !== 1'b1) begin tests_failed++;
            $display("FAIL idle_adv_req: got %b, required 1", imem_req); end
        serve_fetch(32'h0000_0000);
        advance_once(2'b11);
        tests_run++;
        if (pc !== 32'h0000_0004) begin tests_failed++;
            $display("FAIL ctrl11_pc: got %h, required 00000004", pc); end
        serve_fetch(32'h0000_0000);
    endtask

    task automatic test_timeout;
        int n = 0;
        advance_once(2'b00);
        imem_gnt = 1'b1;
        @(negedge clk);
        imem_gnt = 1'b0;
        while (fetch_err !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        tests_run += 4;
        if (n != 16) begin tests_failed++;
            $display("FAIL timeout_cycles: got %0d, required 16", n); end
        if (fetch_err !== 1'b1) begin tests_failed++;
            $display("FAIL timeout_err: got %b, required 1", fetch_err); end
        if (imem_req !== 1'b0) begin tests_failed++;
            $display("FAIL timeout_req: got %b, required 0", imem_req); end
        if (instr_valid !== 1'b0) begin tests_failed++;
            $display("FAIL timeout_valid: got %b, required 0", instr_valid); end
        advance_once(2'b00);
        repeat (3) @(negedge clk);
        tests_run += 3;
        if (fetch_err !== 1'b1) begin tests_failed++;
            $display("FAIL halt_sticky: got %b, required 1", fetch_err); end
        if (pc !== 32'h0000_0008) begin tests_failed++;
            $display("FAIL halt_pc: got %h, required 00000008", pc); end
        if (imem_req !== 1'b0) begin tests_failed++;
            $display("FAIL halt_req: got %b, required 0", imem_req); end
    endtask

    task automatic test_reset_mid_wait;
        #1 reset = 1'b1;
        #1;
        tests_run += 2;
        if (fetch_err !== 1'b0) begin tests_failed++;
            $display("FAIL halt_rst_err: got %b, required 0", fetch_err); end
        if (pc !== 32'h0000_3000) begin tests_failed++;
            $display("FAIL halt_rst_pc: got %h, required 00003000", pc); end
        @(negedge clk);
        reset = 1'b0;
        serve_fetch(32'h2409_0002);
        advance_once(2'b00);
        imem_gnt = 1'b1;
        @(negedge clk);
        imem_gnt = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++;
        if (pc !== 32'h0000_3004) begin tests_failed++;
            $display("FAIL wait_pc: got %h, required 00003004", pc); end
        #1 reset = 1'b1;
        #1;
        tests_run += 5;
        if (pc !== 32'h0000_3000) begin tests_failed++;
            $display("FAIL midwait_rst_pc: got %h, required 00003000", pc); end
        if (imem_req !== 1'b0) begin tests_failed++;
            $display("FAIL midwait_rst_req: got %b, required 0", imem_req); end
        if (instr_valid !== 1'b0) begin tests_failed++;
            $display("FAIL midwait_rst_valid: got %b, required 0", instr_valid); end
        if (instr !== 32'h0) begin tests_failed++;
            $display("FAIL midwait_rst_instr: got %h, required 00000000", instr); end
        if (fetch_err !== 1'b0) begin tests_failed++;
            $display("FAIL midwait_rst_err: got %b, required 0", fetch_err); end
        @(negedge clk);
        reset = 1'b0;
        serve_fetch(32'h2409_0003);
        tests_run += 3;
        if (instr_valid !== 1'b1) begin tests_failed++;
            $display("FAIL recover_valid: got %b, required 1", instr_valid); end
        if (instr !== 32'h2409_0003) begin tests_failed++;
            $display("FAIL recover_instr: got %h, required 24090003", instr); end
        if (pc !== 32'h0000_3000) begin tests_failed++;
            $display("FAIL recover_pc: got %h, required 00003000", pc); end
    endtask

    initial begin
        test_reset();
        test_hold_stable();
        test_sequential();
        test_branch();
        test_jump();
        test_wrap();
        test_timeout();
        test_reset_mid_wait();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
